// File: rtl/rf_pkg.sv
// Shared constants for the RF disk controller buffer arbiter.
package rf_pkg;
  localparam int RF_BUF_AW = 8;
  localparam int RF_BUF_DW = 12;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_H = 1'b1;
endpackage

// File: rtl/ram_256x12.sv
// Single-port synchronous 256x12 buffer RAM with registered read data.
module ram_256x12 (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_ce,
  input  logic        i_we,
  input  logic [7:0]  i_a,
  input  logic [11:0] i_din,
  output logic [11:0] o_dout
);
  logic [11:0] r_mem [0:255];

  // NOTE: the array itself is deliberately not reset so it maps onto a RAM
  // macro; only the output register carries a reset value.
  always_ff @(posedge clk) begin
    if (i_ce && i_we) r_mem[i_a] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (reset)              o_dout <= '0;
    else if (i_ce && !i_we) o_dout <= r_mem[i_a];
  end
endmodule

// File: rtl/rf_buf_rr_pick.sv
// Combinational two-way pick between the disk and host ports with bounded bursts.
module rf_buf_rr_pick
  import rf_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic       i_d_req,
  input  logic       i_h_req,
  input  logic       i_owner,
  input  logic [3:0] i_bcnt,
  output logic       o_gnt_d,
  output logic       o_gnt_h
);
  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  logic w_keep;
  logic w_pick_h;

  // The owner keeps a contested bus only while its burst budget lasts.
  assign w_keep   = (i_bcnt < BMAX);
  assign w_pick_h = w_keep ? (i_owner == PORT_H) : (i_owner == PORT_D);

  assign o_gnt_h = i_h_req & (~i_d_req | w_pick_h);
  assign o_gnt_d = i_d_req & (~i_h_req | ~w_pick_h);
endmodule

// File: rtl/rf_buf_arb.sv
// Shares the 256x12 buffer RAM between the disk (D) and host (H) ports:
// one command per cycle, read data routed back to the issuing port.
module rf_buf_arb
  import rf_pkg::*;
#(
  parameter int AW        = RF_BUF_AW,
  parameter int DW        = RF_BUF_DW,
  parameter int BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_din,
  output logic          ram_ce,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);
  logic       r_owner;
  logic [3:0] r_bcnt;
  logic       r_rd_d;
  logic       r_rd_h;

  logic w_pick_d;
  logic w_pick_h;
  logic w_gnt_d;
  logic w_gnt_h;
  logic w_any;
  logic w_src_h;

  rf_buf_rr_pick #(.BURST_MAX(BURST_MAX)) u_pick (
    .i_d_req (d_req),
    .i_h_req (h_req),
    .i_owner (r_owner),
    .i_bcnt  (r_bcnt),
    .o_gnt_d (w_pick_d),
    .o_gnt_h (w_pick_h)
  );

  assign w_gnt_d = w_pick_d & ~reset;
  assign w_gnt_h = w_pick_h & ~reset;
  assign w_any   = w_gnt_d | w_gnt_h;
  // With no grant the command fields fall back to the owner's port.
  assign w_src_h = w_any ? w_gnt_h : (r_owner == PORT_H);

  assign d_gnt   = w_gnt_d;
  assign h_gnt   = w_gnt_h;
  assign ram_ce  = w_any;
  assign ram_we  = w_any & (w_src_h ? h_we : d_we);
  assign ram_a   = w_src_h ? h_addr  : d_addr;
  assign ram_din = w_src_h ? h_wdata : d_wdata;

  assign d_rvalid = r_rd_d;
  assign h_rvalid = r_rd_h;
  assign d_rdata  = r_rd_d ? ram_dout : '0;
  assign h_rdata  = r_rd_h ? ram_dout : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= PORT_D;
      r_bcnt  <= 4'd0;
      r_rd_d  <= 1'b0;
      r_rd_h  <= 1'b0;
    end else begin
      if (w_any) begin
        if (w_gnt_h == r_owner) begin
          r_bcnt <= (r_bcnt == 4'hF) ? r_bcnt : r_bcnt + 4'd1;
        end else begin
          r_owner <= w_gnt_h;
          r_bcnt  <= 4'd1;
        end
      end
      r_rd_d <= w_gnt_d & ~d_we;
      r_rd_h <= w_gnt_h & ~h_we;
    end
  end
endmodule

// File: tb/tb_rf_buf_arb.sv
// Directed self-checking bench for rf_buf_arb driving a ram_256x12 model.
module tb_rf_buf_arb;
  logic        clk = 1'b0;
  logic        reset;
  logic        d_req, d_we, h_req, h_we;
  logic [7:0]  d_addr, h_addr;
  logic [11:0] d_wdata, h_wdata;
  logic        d_gnt, h_gnt, d_rvalid, h_rvalid;
  logic [11:0] d_rdata, h_rdata;
  logic [7:0]  ram_a;
  logic [11:0] ram_din, ram_dout;
  logic        ram_ce, ram_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_buf_arb dut (
    .clk(clk), .reset(reset),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .ram_a(ram_a), .ram_din(ram_din), .ram_ce(ram_ce), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  ram_256x12 u_ram (
    .clk(clk), .reset(reset), .i_ce(ram_ce), .i_we(ram_we),
    .i_a(ram_a), .i_din(ram_din), .o_dout(ram_dout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
    end
  endtask

  // Applies one cycle of port commands just after the falling edge.
  task automatic drive(input logic dr, input logic dw, input logic [7:0] da, input logic [11:0] dd,
                       input logic hr, input logic hw, input logic [7:0] ha, input logic [11:0] hd);
    @(negedge clk);
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [11:0] h_pat;
  logic        prev_d, prev_h, exp_h;

  initial begin
    reset = 1'b1;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;

    // Reset forces grants and RAM strobes low even with a request pending.
    drive(1, 1, 8'o017, 12'o5252, 0, 0, 0, 0);
    check("rst_d_gnt", d_gnt, 0);
    check("rst_ram_ce", ram_ce, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_d_rvalid", d_rvalid, 0);
    check("rst_h_rvalid", h_rvalid, 0);
    @(negedge clk);
    reset = 1'b0;

    // Write then read back on the disk port.
    drive(1, 1, 8'o017, 12'o5252, 0, 0, 0, 0);
    check("t1_w_d_gnt", d_gnt, 1);
    check("t1_w_h_gnt", h_gnt, 0);
    check("t1_w_ram_we", ram_we, 1);
    check("t1_w_ram_a", ram_a, 8'o017);
    check("t1_w_ram_din", ram_din, 12'o5252);
    drive(1, 0, 8'o017, 0, 0, 0, 0, 0);
    check("t1_r_d_gnt", d_gnt, 1);
    check("t1_r_ram_we", ram_we, 0);
    check("t1_r_ram_ce", ram_ce, 1);
    check("t1_w_no_rvalid", d_rvalid, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("t1_d_rvalid", d_rvalid, 1);
    check("t1_d_rdata", d_rdata, 12'o5252);
    check("t1_h_rvalid", h_rvalid, 0);
    check("t1_idle_ce", ram_ce, 0);

    // Both ports stream reads: bursts of four alternate D,H,D.
    do_reset();
    h_pat  = 12'b0000_1111_0000;
    prev_d = 0;
    prev_h = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 8'(i), 0, 1, 0, 8'(8'o200 + i), 0);
      exp_h = h_pat[i];
      check($sformatf("t2_d_gnt_%0d", i), d_gnt, !exp_h);
      check($sformatf("t2_h_gnt_%0d", i), h_gnt, exp_h);
      check($sformatf("t2_ram_a_%0d", i), ram_a, exp_h ? 8'(8'o200 + i) : 8'(i));
      check($sformatf("t2_d_rvalid_%0d", i), d_rvalid, prev_d);
      check($sformatf("t2_h_rvalid_%0d", i), h_rvalid, prev_h);
      prev_d = !exp_h;
      prev_h = exp_h;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("t2_d_rvalid_end", d_rvalid, prev_d);
    check("t2_h_rvalid_end", h_rvalid, prev_h);

    // Host alone for 20 cycles, then disk joins and wins immediately.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 1, 0, 8'(i), 0);
      check($sformatf("t3_h_gnt_%0d", i), h_gnt, 1);
      check($sformatf("t3_d_gnt_%0d", i), d_gnt, 0);
    end
    drive(1, 0, 8'o100, 0, 1, 0, 8'o020, 0);
    check("t3_join_d_gnt", d_gnt, 1);
    check("t3_join_h_gnt", h_gnt, 0);

    // Fairness count survives idle cycles.
    do_reset();
    drive(1, 0, 8'o001, 0, 0, 0, 0, 0);
    check("t4_d1", d_gnt, 1);
    drive(1, 0, 8'o002, 0, 0, 0, 0, 0);
    check("t4_d2", d_gnt, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("t4_idle1_ce", ram_ce, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("t4_idle2_gnt", d_gnt | h_gnt, 0);
    drive(1, 0, 8'o003, 0, 1, 0, 8'o103, 0);
    check("t4_both1_d", d_gnt, 1);
    drive(1, 0, 8'o004, 0, 1, 0, 8'o104, 0);
    check("t4_both2_d", d_gnt, 1);
    drive(1, 0, 8'o005, 0, 1, 0, 8'o105, 0);
    check("t4_both3_h", h_gnt, 1);
    check("t4_both3_d", d_gnt, 0);

    // A read in flight when reset hits is dropped.
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 8'o377, 0);
    check("t5_h_gnt", h_gnt, 1);
    check("t5_ram_a", ram_a, 8'o377);
    #3 reset = 1'b1;
    drive(0, 0, 0, 0, 1, 0, 8'o377, 0);
    check("t5_rst_h_rvalid", h_rvalid, 0);
    check("t5_rst_h_gnt", h_gnt, 0);
    check("t5_rst_ram_ce", ram_ce, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("t5_rst2_h_rvalid", h_rvalid, 0);
    reset = 1'b0;

    // Host write followed by a disk read of the same word.
    drive(0, 0, 0, 0, 1, 1, 8'o000, 12'o7777);
    check("t6_h_gnt", h_gnt, 1);
    check("t6_ram_we", ram_we, 1);
    drive(1, 0, 8'o000, 0, 0, 0, 0, 0);
    check("t6_d_gnt", d_gnt, 1);
    check("t6_h_rvalid", h_rvalid, 0);
    check("t6_d_rvalid_early", d_rvalid, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("t6_d_rvalid", d_rvalid, 1);
    check("t6_d_rdata", d_rdata, 12'o7777);
    check("t6_h_rvalid_after", h_rvalid, 0);
    check("t6_h_rdata_quiet", h_rdata, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("t6_d_rvalid_clear", d_rvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
